// File: rtl/fsm_prog_streamer.sv
// fsm_prog_streamer: host-side transmitter for the programmable FSM
// controller's serial programming port. Accepts one transition-table entry
// per valid/ready handshake and serialises it MSB-first onto
// prog_enable/prog_data, STATE_COUNT entries per programming run.
//
// Optional feature macro: FSM_PROG_PARITY_EN
//   When defined, each entry is followed by one extra serial bit carrying the
//   even parity (XOR) of the captured word, and the bit counter gains a bit.
module fsm_prog_streamer #(
    parameter int STATE_COUNT = 8,
    parameter int STATE_WIDTH = $clog2(STATE_COUNT),
    parameter int WORD_WIDTH  = 2 * STATE_WIDTH
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   word_valid,
    input  logic [WORD_WIDTH-1:0]  word_data,
    output logic                   word_ready,
    output logic                   prog_enable,
    output logic                   prog_data,
    output logic                   busy,
    output logic                   done,
    output logic [STATE_WIDTH-1:0] entry_idx
);

`ifdef FSM_PROG_PARITY_EN
    // Data bits followed by the parity bit share one shift register.
    localparam int SHIFT_WIDTH = WORD_WIDTH + 1;
    localparam int COUNT_WIDTH = $clog2(WORD_WIDTH + 1) + 1;
`else
    localparam int SHIFT_WIDTH = WORD_WIDTH;
    localparam int COUNT_WIDTH = $clog2(WORD_WIDTH + 1);
`endif

    localparam logic [COUNT_WIDTH-1:0] LAST_BIT   = COUNT_WIDTH'(SHIFT_WIDTH - 1);
    localparam logic [STATE_WIDTH-1:0] LAST_ENTRY = STATE_WIDTH'(STATE_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                   state_reg, state_next;
    logic [SHIFT_WIDTH-1:0]   shift_reg, shift_next;
    logic [COUNT_WIDTH-1:0]   count_reg, count_next;
    logic [STATE_WIDTH-1:0]   entry_reg, entry_next;
    logic                     prog_enable_reg, prog_enable_next;
    logic                     prog_data_reg, prog_data_next;
    logic [SHIFT_WIDTH-1:0]   load_word;

`ifdef FSM_PROG_PARITY_EN
    assign load_word = {word_data, ^word_data};
`else
    assign load_word = word_data;
`endif

    // State, shift path and registered serial outputs; reset clears everything.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            shift_reg       <= '0;
            count_reg       <= '0;
            entry_reg       <= '0;
            prog_enable_reg <= 1'b0;
            prog_data_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            shift_reg       <= shift_next;
            count_reg       <= count_next;
            entry_reg       <= entry_next;
            prog_enable_reg <= prog_enable_next;
            prog_data_reg   <= prog_data_next;
        end
    end

    // Next-state logic; abort overrides every transition out of LOAD and SHIFT.
    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        count_next = count_reg;
        entry_next = entry_reg;

        case (state_reg)
            IDLE: begin
                if (start && !abort) begin
                    state_next = LOAD;
                    entry_next = '0;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_next = IDLE;
                    entry_next = '0;
                    shift_next = '0;
                    count_next = '0;
                end else if (word_valid) begin
                    state_next = SHIFT;
                    shift_next = load_word;
                    count_next = '0;
                end
            end
            SHIFT: begin
                if (abort) begin
                    // Partially shifted entry is dropped.
                    state_next = IDLE;
                    entry_next = '0;
                    shift_next = '0;
                    count_next = '0;
                end else if (count_reg == LAST_BIT) begin
                    shift_next = '0;
                    count_next = '0;
                    if (entry_reg == LAST_ENTRY) begin
                        state_next = DONE;
                        entry_next = '0;
                    end else begin
                        state_next = LOAD;
                        entry_next = entry_reg + 1'b1;
                    end
                end else begin
                    shift_next = shift_reg << 1;
                    count_next = count_reg + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
                entry_next = '0;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Serial outputs are computed from the next state so they appear as flops
    // aligned with the SHIFT cycle that carries each bit.
    always_comb begin
        prog_enable_next = (state_next == SHIFT);
        prog_data_next   = (state_next == SHIFT) && shift_next[SHIFT_WIDTH-1];
    end

    assign word_ready  = (state_reg == LOAD);
    assign busy        = (state_reg == LOAD) || (state_reg == SHIFT);
    assign done        = (state_reg == DONE);
    assign prog_enable = prog_enable_reg;
    assign prog_data   = prog_data_reg;
    assign entry_idx   = entry_reg;

endmodule

// File: tb/tb_fsm_prog_streamer.sv
// Directed self-checking bench for fsm_prog_streamer (STATE_COUNT=8,
// WORD_WIDTH=6). Expected serial bits are derived from the words the bench
// itself presents; FSM_PROG_PARITY_EN selects the parity-bit expectations.
module tb_fsm_prog_streamer;

    localparam int SC = 8;
    localparam int SW = 3;
    localparam int WW = 6;
`ifdef FSM_PROG_PARITY_EN
    localparam int SHW = WW + 1;
`else
    localparam int SHW = WW;
`endif

    logic          clock = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          word_valid;
    logic [WW-1:0] word_data;
    logic          word_ready;
    logic          prog_enable;
    logic          prog_data;
    logic          busy;
    logic          done;
    logic [SW-1:0] entry_idx;

    int checks     = 0;
    int errors     = 0;
    int cyc        = 0;
    int done_count = 0;

    fsm_prog_streamer #(
        .STATE_COUNT(SC)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_ready (word_ready),
        .prog_enable(prog_enable),
        .prog_data  (prog_data),
        .busy       (busy),
        .done       (done),
        .entry_idx  (entry_idx)
    );

    always #5 clock = ~clock;

    // Cycle counter and done-pulse counter, both sampled at the active edge.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (done === 1'b1)
            done_count <= done_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit b of the serial stream for word w: MSB-first data, then parity.
    function automatic logic exp_bit(input logic [WW-1:0] w, input int b);
        if (b < WW)
            return w[WW-1-b];
        return ^w;
    endfunction

    // One programming run. gap_entry/gap_len insert word_valid-low cycles,
    // abort_entry aborts on the 3rd bit of that entry, noise_entry holds
    // start high while that entry shifts, word_mode selects the word pattern.
    task automatic do_run(input int gap_entry, input int gap_len, input int abort_entry,
                          input int noise_entry, input int word_mode);
        int h;
        int d;
        int exp_cycles;
        logic [WW-1:0] w;
        h = 0;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("run_ready", 32'(word_ready), 1);
        check("run_busy", 32'(busy), 1);
        for (int k = 0; k < SC; k++) begin
            w = (word_mode != 0) ? WW'(k * 13 + 45) : WW'(k);
            check("load_idx", 32'(entry_idx), k);
            check("load_ready", 32'(word_ready), 1);
            check("load_pe", 32'(prog_enable), 0);
            if (k == gap_entry) begin
                word_valid = 1'b0;
                word_data  = '1;
                repeat (gap_len) begin
                    @(negedge clock);
                    check("gap_ready", 32'(word_ready), 1);
                    check("gap_pe", 32'(prog_enable), 0);
                    check("gap_pd", 32'(prog_data), 0);
                end
            end
            word_valid = 1'b1;
            word_data  = w;
            if (k == 0)
                h = cyc;
            @(negedge clock);
            for (int b = 0; b < SHW; b++) begin
                if (k == noise_entry)
                    start = 1'b1;
                check("shift_pe", 32'(prog_enable), 1);
                check("shift_pd", 32'(prog_data), 32'(exp_bit(w, b)));
                check("shift_idx", 32'(entry_idx), k);
                if (k == abort_entry && b == 2) begin
                    abort = 1'b1;
                    @(negedge clock);
                    abort      = 1'b0;
                    word_valid = 1'b0;
                    check("abort_pe", 32'(prog_enable), 0);
                    check("abort_busy", 32'(busy), 0);
                    check("abort_idx", 32'(entry_idx), 0);
                    check("abort_done", 32'(done), 0);
                    $display("entry %0d word %02h aborted on bit 2", k, w);
                    return;
                end
                @(negedge clock);
            end
            start = 1'b0;
            $display("entry %0d word %02h streamed", k, w);
        end
        d = cyc;
        exp_cycles = SC * (SHW + 1) + ((gap_entry >= 0 && gap_entry < SC) ? gap_len : 0);
        check("done_pulse", 32'(done), 1);
        check("done_busy", 32'(busy), 0);
        check("done_pe", 32'(prog_enable), 0);
        check("run_cycles", 32'(d - h), 32'(exp_cycles));
        word_valid = 1'b0;
        @(negedge clock);
        check("post_done", 32'(done), 0);
        check("post_idx", 32'(entry_idx), 0);
        check("post_busy", 32'(busy), 0);
        $display("run complete: %0d cycles from first handshake", d - h);
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        word_valid = 1'b0;
        word_data  = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_pe", 32'(prog_enable), 0);
        check("rst_pd", 32'(prog_data), 0);
        check("rst_ready", 32'(word_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_idx", 32'(entry_idx), 0);
        repeat (2) @(negedge clock);
        rst = 1'b0;

        // Full run with words 0x00..0x07 and valid held high.
        do_run(-1, 0, -1, -1, 0);
        check("done_count_1", 32'(done_count), 1);

        // Back-pressure: three idle cycles before entry 2.
        do_run(2, 3, -1, -1, 1);
        check("done_count_2", 32'(done_count), 2);

        // Abort on the 3rd bit of entry 4, then restart from entry 0 with
        // start held high during entry 3's shift.
        do_run(-1, 0, 4, -1, 0);
        check("done_count_abort", 32'(done_count), 2);
        do_run(-1, 0, -1, 3, 1);
        check("done_count_3", 32'(done_count), 3);

        // start with abort in IDLE (valid also held): must stay idle.
        @(negedge clock);
        start      = 1'b1;
        abort      = 1'b1;
        word_valid = 1'b1;
        @(negedge clock);
        start = 1'b0;
        abort = 1'b0;
        check("idle_sa_busy", 32'(busy), 0);
        check("idle_sa_ready", 32'(word_ready), 0);
        check("idle_sa_pe", 32'(prog_enable), 0);
        @(negedge clock);
        word_valid = 1'b0;
        check("idle_sa_busy2", 32'(busy), 0);
        check("done_count_sa", 32'(done_count), 3);
        $display("start+abort in IDLE ignored");

        // Asynchronous reset in the middle of entry 1.
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start      = 1'b0;
        word_valid = 1'b1;
        word_data  = 6'h3F;
        repeat (SHW + 2) @(negedge clock);
        check("pre_rst_pe", 32'(prog_enable), 1);
        check("pre_rst_pd", 32'(prog_data), 1);
        check("pre_rst_idx", 32'(entry_idx), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_pe", 32'(prog_enable), 0);
        check("arst_pd", 32'(prog_data), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_ready", 32'(word_ready), 0);
        check("arst_idx", 32'(entry_idx), 0);
        check("arst_done", 32'(done), 0);
        @(negedge clock);
        rst        = 1'b0;
        word_valid = 1'b0;
        $display("asynchronous reset mid-shift cleared outputs");
        do_run(-1, 0, -1, -1, 1);
        check("done_count_4", 32'(done_count), 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fsm_prog_streamer.md
Name: fsm_prog_streamer

Overview:
- Host-side transmitter for the programmable FSM controller's serial programming port.
- Accepts one transition-table entry per word over a valid/ready handshake.
- Serialises each entry MSB-first onto prog_enable/prog_data, one bit per clock, until STATE_COUNT entries have been sent.
- Sits between a host loader (SPI/UART bridge or test sequencer) and the controller's prog_enable/prog_data inputs.

Parameters:
- STATE_COUNT, 8, number of table entries streamed per programming run (one per state).
- STATE_WIDTH, $clog2(STATE_COUNT), width of one next-state field.
- WORD_WIDTH, 2*STATE_WIDTH, bits per entry: {next_state_if_in1, next_state_if_in0}.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a programming run; sampled only in IDLE.
- abort  input  1  cancels a run in progress; returns to IDLE on the next edge.
- word_valid  input  1  host presents an entry on word_data.
- word_data  input  WORD_WIDTH  entry to be serialised.
- word_ready  output  1  high only in LOAD; a transfer occurs when word_valid && word_ready.
- prog_enable  output  1  high exactly during cycles carrying a valid programming bit.
- prog_data  output  1  current serial bit; driven 0 whenever prog_enable is 0.
- busy  output  1  high in LOAD and SHIFT.
- done  output  1  single-cycle pulse after the last bit of the last entry.
- entry_idx  output  STATE_WIDTH  index of the entry currently being loaded or shifted.

Behaviour:
- Reset values:
  - State: IDLE.
  - All outputs 0: prog_enable, prog_data, word_ready, busy, done, entry_idx.
  - Shift register and bit counter cleared.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - start=1 goes to LOAD with entry_idx=0.
  - start in any other state is ignored.
- LOAD:
  - word_ready=1 (combinational from state).
  - On a handshake, capture word_data into the shift register, clear the bit counter, go to SHIFT.
  - Without word_valid, stay in LOAD with prog_enable=0 (gaps are legal; the controller shifts only on prog_enable).
- SHIFT:
  - prog_enable=1; prog_data = shift-register MSB. Both are registered outputs.
  - Shift left each cycle; exactly WORD_WIDTH cycles per entry.
  - After the last bit:
    - If entry_idx == STATE_COUNT-1, go to DONE.
    - Otherwise increment entry_idx and go to LOAD.
- DONE:
  - done=1 for one cycle, busy=0, then IDLE.
  - entry_idx returns to 0.
- Latency:
  - First bit appears on prog_enable/prog_data one cycle after the LOAD handshake.
  - With word_valid held high, each entry costs WORD_WIDTH+1 cycles: one LOAD cycle plus the shift cycles.
- abort:
  - Takes priority over every other transition in LOAD and SHIFT.
  - Next edge: IDLE, prog_enable=0, entry_idx=0, no done pulse.
  - A partially shifted entry is discarded.
  - abort in IDLE or DONE has no effect (DONE still pulses).
- start and abort asserted together in IDLE: abort wins; stay in IDLE.
- Reset mid-run has the same effect as abort, but is asynchronous.
- entry_idx does not wrap during a run; the final-entry compare uses STATE_COUNT-1, so non-power-of-two STATE_COUNT is supported.
- word_data is ignored outside LOAD handshakes; holding word_valid in IDLE has no effect.

Optional Feature:
- Macro: FSM_PROG_PARITY_EN.
- Defined:
  - After the WORD_WIDTH data bits, one extra SHIFT cycle carries the even-parity bit (XOR of the captured word) with prog_enable=1.
  - Each entry therefore costs WORD_WIDTH+2 cycles with continuous valid.
  - The bit counter is widened by one bit.
- Undefined: no parity bit; timing exactly as in Behaviour.

Test Plan:
- Full run, STATE_COUNT=8, WORD_WIDTH=6, word_valid held high with words 0x00..0x07:
  - 48 prog_enable cycles in 8 bursts of 6, each burst preceded by one LOAD cycle.
  - Bit stream MSB-first; 0x05 is sent as 000101.
  - done pulses once, 56 cycles after the first handshake.
- Back-pressure: word_valid low for 3 cycles before entry 2:
  - word_ready stays high, prog_enable stays 0 for those cycles.
  - Stream content unchanged; done delayed by 3 cycles.
- abort asserted during the 3rd bit of entry 4:
  - Next cycle: prog_enable=0, busy=0, entry_idx=0, no done.
  - A following start restarts at entry 0.
- rst asserted asynchronously mid-SHIFT:
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release, start produces a clean full run.
- start pulses while busy and simultaneously with abort in IDLE: no state change, no extra run, done count unchanged.
- With FSM_PROG_PARITY_EN, word 0x2D (101101):
  - Stream is 1011010 (parity 0); word 0x01 is sent as 0000011.
  - Full run takes 64 cycles from the first handshake.
